// File: rtl/gf2m_reduce_283.sv
// gf2m_reduce_283
//   Sequential reducer for GF(2^283) products. It takes a 565-bit unreduced
//   polynomial product and reduces it modulo
//   f(x) = x^283 + x^12 + x^7 + x^5 + 1. Each clock it folds a FOLD-bit
//   window of high-order coefficients. The window walks down from bit 564
//   towards bit 283.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   c_in holds a product to reduce
//   in_ready   block can accept (registered; high only in IDLE)
//   c_in       565-bit unreduced product, bit i = coefficient of x^i
//   out_valid  r_out holds a result (registered)
//   out_ready  downstream accepts r_out
//   r_out      283-bit reduced result (registered)
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for a product, in_ready=1
//   S_FOLD | folding one window per cycle, step 0..NSTEP-1
//   S_DONE | holding r_out/out_valid until out_ready

module gf2m_reduce_283 #(
  parameter int FOLD = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [564:0] c_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [282:0] r_out
);

  localparam int NSTEP = (282 + FOLD - 1) / FOLD;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FOLD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] step;
  logic [564:0]  acc;
  logic [564:0]  acc_next;
  int            hi;
  int            k;

  // Fold of the current window. x^k = x^(k-283) * (x^12 + x^7 + x^5 + 1),
  // so each set bit k lands on k-283, k-278, k-276 and k-271. Every
  // destination is at most hi-271. That is below the window, so bits that
  // spill back above 283 are picked up by a later window. Bits below 283
  // are excluded from the window, which covers the short final window.
  always_comb begin
    acc_next = acc;
    hi       = 564 - int'(step) * FOLD;
    k        = 0;
    for (int j = 0; j < FOLD; j++) begin
      k = hi - j;
      if (k >= 283) begin
        if (acc[10'(k)]) begin
          acc_next[10'(k)]       = 1'b0;
          acc_next[10'(k - 283)] = ~acc_next[10'(k - 283)];
          acc_next[10'(k - 278)] = ~acc_next[10'(k - 278)];
          acc_next[10'(k - 276)] = ~acc_next[10'(k - 276)];
          acc_next[10'(k - 271)] = ~acc_next[10'(k - 271)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step      <= '0;
      acc       <= '0;
      r_out     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= c_in;
            step     <= '0;
            in_ready <= 1'b0;
            state    <= S_FOLD;
          end
        end
        S_FOLD: begin
          acc <= acc_next;
          if (step == SW'(NSTEP - 1)) begin
            r_out     <= acc_next[282:0];
            out_valid <= 1'b1;
            step      <= '0;
            state     <= S_DONE;
          end else begin
            step <= step + 1'b1;
          end
        end
        S_DONE: begin
          // Acceptance waits for the cycle after the handshake. A result
          // handshake and a new input never share an edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
